// File: rtl/jelly3_video_format_regularizer_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : jelly3_video_format_regularizer_ctl
//  Function : Run/stop/one-shot sequencer and parameter-update handshaker
//             for jelly3_video_format_regularizer_core.
//  Option   : VIDEO_REGULARIZER_CTL_IRQ_EN enables the sticky interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module jelly3_video_format_regularizer_ctl #(
   parameter int WIDTH_BITS       = 12,
   parameter int HEIGHT_BITS      = 12,
   parameter int INDEX_BITS       = 1,
   parameter int FRAME_TIMER_BITS = 32,
   parameter int TIMER_BITS       = 32,
   parameter int DATA_BITS        = 24,
   parameter int FCNT_BITS        = 16
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        aclken,

   input  logic                        req_start,
   input  logic                        req_oneshot,
   input  logic                        req_stop,
   input  logic                        req_update,

   input  logic [WIDTH_BITS-1:0]       new_width,
   input  logic [HEIGHT_BITS-1:0]      new_height,
   input  logic [DATA_BITS-1:0]        new_fill,
   input  logic [TIMER_BITS-1:0]       new_timeout,
   input  logic [FRAME_TIMER_BITS-1:0] new_frm_timeout,
   input  logic                        new_frm_timer_en,
   input  logic                        new_skip,

   output logic                        ctl_enable,
   output logic                        ctl_update,
   output logic                        ctl_skip,
   output logic                        ctl_frm_timer_en,
   output logic [FRAME_TIMER_BITS-1:0] ctl_frm_timeout,

   output logic [WIDTH_BITS-1:0]       param_width,
   output logic [HEIGHT_BITS-1:0]      param_height,
   output logic [DATA_BITS-1:0]        param_fill,
   output logic [TIMER_BITS-1:0]       param_timeout,

   input  logic [INDEX_BITS-1:0]       ctl_index,
   input  logic                        ctl_busy,

   output logic [1:0]                  sts_state,
   output logic                        sts_upd_pending,
   output logic                        sts_upd_done,
   output logic [FCNT_BITS-1:0]        sts_frame_cnt,

   output logic                        irq,
   input  logic                        irq_clr
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_RUN     = 2'd1;
   localparam logic [1:0] c_ONESHOT = 2'd2;
   localparam logic [1:0] c_DRAIN   = 2'd3;

   logic [1:0]                  r_state;
   logic [1:0]                  w_state_next;
   logic                        w_enable_next;
   logic                        r_ctl_enable;

   logic                        r_ctl_update;
   logic                        r_arm;
   logic                        r_pending;
   logic                        r_upd_done;
   logic [INDEX_BITS-1:0]       r_snap;
   logic                        w_accept;

   logic [WIDTH_BITS-1:0]       r_width;
   logic [HEIGHT_BITS-1:0]      r_height;
   logic [DATA_BITS-1:0]        r_fill;
   logic [TIMER_BITS-1:0]       r_timeout;
   logic [FRAME_TIMER_BITS-1:0] r_frm_timeout;
   logic                        r_frm_timer_en;
   logic                        r_skip;

   logic                        r_busy_prev;
   logic                        w_busy_fall;
   logic [FCNT_BITS-1:0]        r_frame_cnt;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= c_IDLE;
      end else if (aclken) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (req_oneshot) begin
               w_state_next = c_ONESHOT;
            end else if (req_start) begin
               w_state_next = c_RUN;
            end
         end
         c_RUN: begin
            if (req_stop) begin
               w_state_next = c_DRAIN;
            end
         end
         // Once the core goes busy it has committed to the frame, so enable may drop.
         c_ONESHOT: begin
            if (ctl_busy || req_stop) begin
               w_state_next = c_DRAIN;
            end
         end
         c_DRAIN: begin
            if (!ctl_busy) begin
               w_state_next = c_IDLE;
            end
         end
         default: w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_enable_next = (w_state_next == c_RUN) || (w_state_next == c_ONESHOT);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ctl_enable <= 1'b0;
      end else if (aclken) begin
         r_ctl_enable <= w_enable_next;
      end
   end

   // ------------------------------------------------------- update handshake
   // ctl_update is held low for the cycle the shadow changes, so the core only
   // ever sees a shadow set that has been stable for at least one cycle.
   assign w_accept = r_pending && r_ctl_update && (ctl_index != r_snap) && !req_update;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_ctl_update   <= 1'b0;
         r_arm          <= 1'b0;
         r_pending      <= 1'b0;
         r_upd_done     <= 1'b0;
         r_snap         <= '0;
         r_width        <= '0;
         r_height       <= '0;
         r_fill         <= '0;
         r_timeout      <= '0;
         r_frm_timeout  <= '0;
         r_frm_timer_en <= 1'b0;
         r_skip         <= 1'b0;
      end else if (aclken) begin
         r_upd_done <= 1'b0;
         if (req_update) begin
            r_width        <= new_width;
            r_height       <= new_height;
            r_fill         <= new_fill;
            r_timeout      <= new_timeout;
            r_frm_timeout  <= new_frm_timeout;
            r_frm_timer_en <= new_frm_timer_en;
            r_skip         <= new_skip;
            r_pending      <= 1'b1;
            r_ctl_update   <= 1'b0;
            r_arm          <= 1'b1;
         end else if (r_arm) begin
            r_ctl_update <= 1'b1;
            r_snap       <= ctl_index;
            r_arm        <= 1'b0;
         end else if (w_accept) begin
            r_pending    <= 1'b0;
            r_ctl_update <= 1'b0;
            r_upd_done   <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------- frame counter
   assign w_busy_fall = r_busy_prev && !ctl_busy;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_busy_prev <= 1'b0;
         r_frame_cnt <= '0;
      end else if (aclken) begin
         r_busy_prev <= ctl_busy;
         if (w_busy_fall) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------- interrupt
`ifdef VIDEO_REGULARIZER_CTL_IRQ_EN
   logic r_irq;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_irq <= 1'b0;
      end else if (aclken) begin
         if (w_busy_fall || w_accept) begin
            r_irq <= 1'b1;
         end else if (irq_clr) begin
            r_irq <= 1'b0;
         end
      end
   end

   assign irq = r_irq;
`else
   logic w_unused_irq_clr;
   assign w_unused_irq_clr = irq_clr;
   assign irq              = 1'b0;
`endif

   assign ctl_enable       = r_ctl_enable;
   assign ctl_update       = r_ctl_update;
   assign ctl_skip         = r_skip;
   assign ctl_frm_timer_en = r_frm_timer_en;
   assign ctl_frm_timeout  = r_frm_timeout;
   assign param_width      = r_width;
   assign param_height     = r_height;
   assign param_fill       = r_fill;
   assign param_timeout    = r_timeout;
   assign sts_state        = r_state;
   assign sts_upd_pending  = r_pending;
   assign sts_upd_done     = r_upd_done;
   assign sts_frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jelly3_video_format_regularizer_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jelly3_video_format_regularizer_ctl
//  Function : Directed self-checking bench with a per-cycle reference model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jelly3_video_format_regularizer_ctl;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        aclken = 1'b1;
   logic        req_start = 1'b0, req_oneshot = 1'b0, req_stop = 1'b0, req_update = 1'b0;
   logic [11:0] new_width = '0, new_height = '0;
   logic [23:0] new_fill = '0;
   logic [31:0] new_timeout = '0, new_frm_timeout = '0;
   logic        new_frm_timer_en = 1'b0, new_skip = 1'b0;
   logic        ctl_enable, ctl_update, ctl_skip, ctl_frm_timer_en;
   logic [31:0] ctl_frm_timeout;
   logic [11:0] param_width, param_height;
   logic [23:0] param_fill;
   logic [31:0] param_timeout;
   logic [0:0]  ctl_index = 1'b0;
   logic        ctl_busy = 1'b0;
   logic [1:0]  sts_state;
   logic        sts_upd_pending, sts_upd_done;
   logic [15:0] sts_frame_cnt;
   logic        irq;
   logic        irq_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   jelly3_video_format_regularizer_ctl dut (
      .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
      .req_start(req_start), .req_oneshot(req_oneshot), .req_stop(req_stop), .req_update(req_update),
      .new_width(new_width), .new_height(new_height), .new_fill(new_fill), .new_timeout(new_timeout),
      .new_frm_timeout(new_frm_timeout), .new_frm_timer_en(new_frm_timer_en), .new_skip(new_skip),
      .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_skip(ctl_skip),
      .ctl_frm_timer_en(ctl_frm_timer_en), .ctl_frm_timeout(ctl_frm_timeout),
      .param_width(param_width), .param_height(param_height), .param_fill(param_fill),
      .param_timeout(param_timeout), .ctl_index(ctl_index), .ctl_busy(ctl_busy),
      .sts_state(sts_state), .sts_upd_pending(sts_upd_pending), .sts_upd_done(sts_upd_done),
      .sts_frame_cnt(sts_frame_cnt), .irq(irq), .irq_clr(irq_clr)
   );

   always #5 aclk = ~aclk;

   // ---------------------------------------------------------- reference model
   // mode: 0 stopped, 1 free-running, 2 single frame, 3 waiting for frame end
   int          m_mode;
   logic        m_en, m_upd, m_pend, m_done, m_irq, m_settle, m_prev;
   logic [0:0]  m_idx_seen;
   logic [15:0] m_frames;
   logic [11:0] m_w, m_h;
   logic [23:0] m_fill;
   logic [31:0] m_to, m_fto;
   logic        m_ften, m_skip;
   logic        m_ended, m_took;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_mode = 0; m_en = 0; m_upd = 0; m_pend = 0; m_done = 0; m_irq = 0;
         m_settle = 0; m_prev = 0; m_idx_seen = 0; m_frames = 0;
         m_w = 0; m_h = 0; m_fill = 0; m_to = 0; m_fto = 0; m_ften = 0; m_skip = 0;
      end else if (aclken) begin
         m_ended = m_prev && !ctl_busy;
         m_took  = m_pend && m_upd && (ctl_index != m_idx_seen) && !req_update;
         if (m_mode == 0 && req_oneshot)                      m_mode = 2;
         else if (m_mode == 0 && req_start)                   m_mode = 1;
         else if (m_mode == 1 && req_stop)                    m_mode = 3;
         else if (m_mode == 2 && (ctl_busy || req_stop))      m_mode = 3;
         else if (m_mode == 3 && !ctl_busy)                   m_mode = 0;
         m_en   = (m_mode == 1) || (m_mode == 2);
         m_done = m_took;
         if (req_update) begin
            {m_w, m_h, m_fill, m_to, m_fto, m_ften, m_skip} =
               {new_width, new_height, new_fill, new_timeout, new_frm_timeout, new_frm_timer_en, new_skip};
            m_pend = 1; m_upd = 0; m_settle = 1;
         end else if (m_settle) begin
            m_upd = 1; m_idx_seen = ctl_index; m_settle = 0;
         end else if (m_took) begin
            m_pend = 0; m_upd = 0;
         end
         if (m_ended) m_frames = m_frames + 16'd1;
         m_prev = ctl_busy;
`ifdef VIDEO_REGULARIZER_CTL_IRQ_EN
         if (m_ended || m_took) m_irq = 1;
         else if (irq_clr)      m_irq = 0;
`endif
      end
   end

   wire [136:0] w_dut = {sts_state, ctl_enable, ctl_update, ctl_skip, ctl_frm_timer_en, ctl_frm_timeout,
                         param_width, param_height, param_fill, param_timeout,
                         sts_upd_pending, sts_upd_done, sts_frame_cnt, irq};
   wire [136:0] w_mdl = {m_mode[1:0], m_en, m_upd, m_skip, m_ften, m_fto, m_w, m_h, m_fill, m_to,
                         m_pend, m_done, m_frames, m_irq};

   always @(negedge aclk) begin
      checks++;
      if (w_dut !== w_mdl) begin
         errors++;
         $display("FAIL model t=%0t dut=%h model=%h", $time, w_dut, w_mdl);
      end
   end

   // ---------------------------------------------------------- helpers
   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic set_params(input int w, input int h, input int seed);
      new_width        = w[11:0];
      new_height       = h[11:0];
      new_fill         = 24'hA5_0000 + seed[23:0];
      new_timeout      = 32'h1000_0000 + seed;
      new_frm_timeout  = 32'h2000_0000 + seed;
      new_frm_timer_en = seed[0];
      new_skip         = seed[1];
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      step(3);
      chk("reset_state", {30'd0, sts_state}, 32'd0);
      chk("reset_enable", {31'd0, ctl_enable}, 32'd0);
      chk("reset_cnt", {16'd0, sts_frame_cnt}, 32'd0);
      aresetn = 1'b1;
      step(2);

      // update in IDLE, accepted on index 0->1
      set_params(640, 480, 3);
      req_update = 1'b1; step(1); req_update = 1'b0;
      chk("upd_pending", {31'd0, sts_upd_pending}, 32'd1);
      chk("upd_low_first", {31'd0, ctl_update}, 32'd0);
      step(1);
      chk("upd_high", {31'd0, ctl_update}, 32'd1);
      chk("width_640", {20'd0, param_width}, 32'd640);
      chk("height_480", {20'd0, param_height}, 32'd480);
      ctl_index = 1'b1; step(1);
      chk("upd_done", {31'd0, sts_upd_done}, 32'd1);
      chk("upd_clear", {31'd0, sts_upd_pending}, 32'd0);
      step(1);
      chk("upd_done_pulse", {31'd0, sts_upd_done}, 32'd0);

      // superseding update on the same cycle as an index change
      set_params(320, 240, 6);
      req_update = 1'b1; step(1); req_update = 1'b0;
      step(1);
      set_params(800, 600, 9);
      ctl_index = 1'b0; req_update = 1'b1; step(1); req_update = 1'b0;
      chk("supersede_no_done", {31'd0, sts_upd_done}, 32'd0);
      chk("supersede_upd_low", {31'd0, ctl_update}, 32'd0);
      chk("supersede_width", {20'd0, param_width}, 32'd800);
      step(2);
      chk("supersede_upd_high", {31'd0, ctl_update}, 32'd1);
      ctl_index = 1'b1; step(1);
      chk("supersede_done", {31'd0, sts_upd_done}, 32'd1);

      // one-shot, core busy for 100 cycles
      req_oneshot = 1'b1; step(1); req_oneshot = 1'b0;
      chk("oneshot_state", {30'd0, sts_state}, 32'd2);
      step(1);
      ctl_busy = 1'b1; step(1);
      chk("oneshot_drain", {30'd0, sts_state}, 32'd3);
      chk("oneshot_en_drop", {31'd0, ctl_enable}, 32'd0);
      step(99);
      ctl_busy = 1'b0; step(1);
      chk("oneshot_idle", {30'd0, sts_state}, 32'd0);
      chk("oneshot_cnt", {16'd0, sts_frame_cnt}, 32'd1);

      // asynchronous reset while running with a busy core and a pending update
      set_params(100, 50, 2);
      req_start = 1'b1; req_update = 1'b1; step(1); req_start = 1'b0; req_update = 1'b0;
      ctl_busy = 1'b1; step(3);
      chk("run_before_rst", {30'd0, sts_state}, 32'd1);
      #3 aresetn = 1'b0;
      #1;
      chk("async_state", {30'd0, sts_state}, 32'd0);
      chk("async_enable", {31'd0, ctl_enable}, 32'd0);
      chk("async_update", {31'd0, ctl_update}, 32'd0);
      chk("async_cnt", {16'd0, sts_frame_cnt}, 32'd0);
      ctl_busy = 1'b0;
      step(2);
      aresetn = 1'b1;
      step(1);

      // three frames in RUN, stop mid third frame, start/oneshot ignored in DRAIN
      req_start = 1'b1; step(1); req_start = 1'b0;
      chk("run_state", {30'd0, sts_state}, 32'd1);
      for (int f = 0; f < 3; f++) begin
         step(2);
         ctl_busy = 1'b1; step(10);
         if (f == 2) begin
            req_stop = 1'b1; step(1); req_stop = 1'b0;
            chk("stop_drain", {30'd0, sts_state}, 32'd3);
            req_start = 1'b1; step(1); req_start = 1'b0;
            req_oneshot = 1'b1; step(1); req_oneshot = 1'b0;
            chk("drain_ignores", {30'd0, sts_state}, 32'd3);
         end
         ctl_busy = 1'b0; step(1);
      end
      chk("run_idle", {30'd0, sts_state}, 32'd0);
      chk("run_cnt3", {16'd0, sts_frame_cnt}, 32'd3);

      // clock-enable stall across an acceptance
      set_params(1920, 1080, 5);
      req_update = 1'b1; step(1); req_update = 1'b0;
      step(1);
      ctl_index = ~ctl_index; aclken = 1'b0;
      step(5);
      chk("stall_no_done", {31'd0, sts_upd_done}, 32'd0);
      chk("stall_pending", {31'd0, sts_upd_pending}, 32'd1);
      aclken = 1'b1; step(1);
      chk("stall_done", {31'd0, sts_upd_done}, 32'd1);
      chk("stall_cleared", {31'd0, sts_upd_pending}, 32'd0);

      // interrupt at frame end
      req_start = 1'b1; step(1); req_start = 1'b0;
      ctl_busy = 1'b1; step(4);
      req_stop = 1'b1; step(1); req_stop = 1'b0;
      ctl_busy = 1'b0; step(1);
      chk("frame_cnt4", {16'd0, sts_frame_cnt}, 32'd4);
`ifdef VIDEO_REGULARIZER_CTL_IRQ_EN
      chk("irq_set", {31'd0, irq}, 32'd1);
      irq_clr = 1'b1; step(1); irq_clr = 1'b0;
      chk("irq_clr", {31'd0, irq}, 32'd0);
`else
      chk("irq_tied", {31'd0, irq}, 32'd0);
      irq_clr = 1'b1; step(1); irq_clr = 1'b0;
      chk("irq_tied_clr", {31'd0, irq}, 32'd0);
`endif
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
